exec_stage: RTL and testbench



---
 rtl/exec_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_exec_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: ALU, NZCV flag register, condition check and iterative MUL/MOD unit.
// Latency: ADD/SUB/AND/ORR/MOV give their result in the same cycle; MUL/MOD take WIDTH+1 stall cycles, then a DONE cycle.
// Backpressure: stallE holds IF/ID and ID/EX while MUL/MOD runs; writes toward EX/MEM are suppressed while stalled.
module exec_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCSrcE,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MemWriteE,
   input  logic [2:0]       ALUControlE,
   input  logic             ALUSrcE,
   input  logic [1:0]       FlagWriteE,
   input  logic [3:0]       condE,
   input  logic [3:0]       WA3E,
   input  logic [WIDTH-1:0] rd1E,
   input  logic [WIDTH-1:0] rd2E,
   input  logic [WIDTH-1:0] ExtImmE,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [3:0]       WA3M,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             MemtoRegM,
   output logic             PCSrcM,
   output logic             stallE,
   output logic [3:0]       FlagsE
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_MOV = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_MOD = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [3:0]        flags;        // {N,Z,C,V}
   logic              cond_ex;
   logic              is_multi;
   logic              issue;

   // single-cycle ALU
   logic [WIDTH-1:0]  src_b;
   logic [WIDTH:0]    sum_add;
   logic [WIDTH:0]    sum_sub;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_c;
   logic              alu_v;
   logic              alu_cv_en;

   // iterative unit: acc is the MUL accumulator or the MOD partial remainder,
   // sa is the shifting multiplicand or dividend, sb the multiplier or divisor
   logic [WIDTH:0]    acc;
   logic [WIDTH-1:0]  sa;
   logic [WIDTH-1:0]  sb;
   logic              op_mod;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    rem_sh;
   logic              rem_ge;

   logic              flag_we_nz;
   logic              flag_we_cv;

   assign FlagsE   = flags;
   assign src_b    = ALUSrcE ? ExtImmE : rd2E;
   assign is_multi = (ALUControlE == OP_MUL) || (ALUControlE == OP_MOD);
   assign sum_add  = {1'b0, rd1E} + {1'b0, src_b};
   assign sum_sub  = {1'b0, rd1E} - {1'b0, src_b};

   // condition decode against the current flag register
   always_comb begin
      cond_ex = 1'b0;
      case (condE)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // single-cycle result and carry/overflow; MUL/MOD/reserved fall back to ADD here
   always_comb begin
      alu_res   = sum_add[WIDTH-1:0];
      alu_c     = sum_add[WIDTH];
      alu_v     = (rd1E[WIDTH-1] == src_b[WIDTH-1]) && (sum_add[WIDTH-1] != rd1E[WIDTH-1]);
      alu_cv_en = 1'b1;
      case (ALUControlE)
         OP_SUB: begin
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = ~sum_sub[WIDTH];
            alu_v   = (rd1E[WIDTH-1] != src_b[WIDTH-1]) && (sum_sub[WIDTH-1] != rd1E[WIDTH-1]);
         end
         OP_AND: begin
            alu_res   = rd1E & src_b;
            alu_cv_en = 1'b0;
         end
         OP_ORR: begin
            alu_res   = rd1E | src_b;
            alu_cv_en = 1'b0;
         end
         OP_MOV: begin
            alu_res   = src_b;
            alu_cv_en = 1'b0;
         end
         default: ;
      endcase
   end

   // one iteration of shift-add multiply / restoring remainder
   assign mul_sum = acc + {1'b0, sa};
   assign rem_sh  = {acc[WIDTH-1:0], sa[WIDTH-1]};
   assign rem_ge  = (rem_sh >= {1'b0, sb});

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state, stall and issue decode
   always_comb begin
      state_nx = state;
      stallE   = 1'b0;
      issue    = 1'b0;
      case (state)
         IDLE: begin
            if (is_multi && cond_ex) begin
               issue    = 1'b1;
               stallE   = 1'b1;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            stallE = 1'b1;
            if (cnt == '0) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // operand latch on issue, then one iteration per BUSY cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         sa     <= '0;
         sb     <= '0;
         op_mod <= 1'b0;
      end else if (issue) begin
         cnt    <= CW'(WIDTH - 1);
         acc    <= '0;
         sa     <= rd1E;
         sb     <= src_b;
         op_mod <= (ALUControlE == OP_MOD);
      end else if (state == BUSY) begin
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (op_mod) begin
            sa  <= sa << 1;
            acc <= rem_ge ? (rem_sh - {1'b0, sb}) : rem_sh;
         end else begin
            if (sb[0]) acc <= mul_sum;
            sa <= sa << 1;
            sb <= sb >> 1;
         end
      end
   end

   // the latched product/remainder is presented only in DONE
   assign ALUResultM = (state == DONE) ? acc[WIDTH-1:0] : alu_res;

   // N,Z follow any completing op; C,V only from single-cycle arithmetic
   assign flag_we_nz = cond_ex && FlagWriteE[1] &&
                       (((state == IDLE) && !is_multi) || (state == DONE));
   assign flag_we_cv = cond_ex && FlagWriteE[0] && alu_cv_en &&
                       (state == IDLE) && !is_multi;

   // NZCV flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= 4'b0000;
      end else begin
         if (flag_we_nz) begin
            flags[3] <= ALUResultM[WIDTH-1];
            flags[2] <= (ALUResultM == '0);
         end
         if (flag_we_cv) begin
            flags[1] <= alu_c;
            flags[0] <= alu_v;
         end
      end
   end

   assign WriteDataM = rd2E;
   assign WA3M       = WA3E;
   assign MemtoRegM  = MemtoRegE;
   assign RegWriteM  = RegWriteE & cond_ex & ~stallE;
   assign MemWriteM  = MemWriteE & cond_ex & ~stallE;
   assign PCSrcM     = PCSrcE    & cond_ex & ~stallE;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a cycle-stamped expectation queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_exec_stage;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, ORR = 3'b011;
   localparam logic [2:0] MUL = 3'b101, MOD = 3'b110;
   localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, GE = 4'b1010, LT = 4'b1011;
   localparam logic [3:0] AL = 4'b1110, NV = 4'b1111;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [1:0]  FlagWriteE;
   logic [3:0]  condE, WA3E;
   logic [31:0] rd1E, rd2E, ExtImmE;
   logic [31:0] ALUResultM, WriteDataM;
   logic [3:0]  WA3M, FlagsE;
   logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM, stallE;

   exec_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .FlagWriteE(FlagWriteE),
      .condE(condE), .WA3E(WA3E), .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM), .stallE(stallE), .FlagsE(FlagsE)
   );

   always #5 clk = ~clk;

   typedef enum {K_RES, K_FLAGS, K_STALL, K_RW, K_MW, K_PC} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: pops every expectation stamped for the current cycle
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_RES:   act = ALUResultM;
            K_FLAGS: act = {28'd0, FlagsE};
            K_STALL: act = {31'd0, stallE};
            K_RW:    act = {31'd0, RegWriteM};
            K_MW:    act = {31'd0, MemWriteM};
            default: act = {31'd0, PCSrcM};
         endcase
         vectors++;
         if (act !== e.val) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, act, e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input kind_e k, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc  = cyc;
      e.kind = k;
      e.val  = v;
      e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic set_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fw, input logic [3:0] cond, input logic rw);
      ALUControlE = ctl;
      rd1E        = a;
      rd2E        = b;
      FlagWriteE  = fw;
      condE       = cond;
      RegWriteE   = rw;
      ALUSrcE     = 1'b0;
      ExtImmE     = 32'd0;
      MemWriteE   = 1'b0;
      PCSrcE      = 1'b0;
      MemtoRegE   = 1'b0;
      WA3E        = 4'd3;
   endtask

   task automatic nop();
      set_op(ADD, 32'd0, 32'd0, 2'b00, NV, 1'b0);
   endtask

   // expects a full multi-cycle op issued in the current cycle; leaves the bench in DONE
   task automatic run_multi(input string n);
      for (int i = 0; i < 33; i++) begin
         chk(K_STALL, 32'd1, {n, "_stall"});
         chk(K_RW, 32'd0, {n, "_rw_gated"});
         if (i == 5) begin
            rd1E = 32'hDEAD_BEEF;
            rd2E = 32'd3;
         end
         step();
      end
      chk(K_STALL, 32'd0, {n, "_done_stall"});
      chk(K_RW, 32'd1, {n, "_done_rw"});
   endtask

   initial begin
      rst = 1'b1;
      nop();
      step();
      step();
      rst = 1'b0;
      chk(K_FLAGS, 32'h0, "reset_flags");
      chk(K_STALL, 32'h0, "reset_stall");
      step();

      // ADD with signed overflow
      set_op(ADD, 32'h7FFF_FFFF, 32'h1, 2'b11, AL, 1'b1);
      chk(K_RES, 32'h8000_0000, "add_ovf_res");
      chk(K_RW, 32'd1, "add_ovf_rw");
      #1;
      vectors++;
      if (ALUResultM !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL add_ovf_res_direct: got %h", ALUResultM);
      end
      step();
      nop();
      chk(K_FLAGS, 32'b1001, "add_ovf_flags");
      step();

      // SUB equal -> Z,C; then EQ passes, NE fails
      set_op(SUB, 32'd5, 32'd5, 2'b11, AL, 1'b0);
      chk(K_RES, 32'd0, "sub_eq_res");
      step();
      set_op(ADD, 32'd3, 32'd4, 2'b00, EQ, 1'b1);
      chk(K_FLAGS, 32'b0110, "sub_eq_flags");
      chk(K_RW, 32'd1, "eq_rw");
      chk(K_RES, 32'd7, "eq_res");
      step();
      set_op(ADD, 32'd3, 32'd4, 2'b00, NE, 1'b1);
      PCSrcE = 1'b1;
      MemWriteE = 1'b1;
      chk(K_RW, 32'd0, "ne_rw");
      chk(K_PC, 32'd0, "ne_pc");
      chk(K_MW, 32'd0, "ne_mw");
      step();

      // ORR from immediate; C,V kept
      set_op(ORR, 32'h8000_0000, 32'h1, 2'b11, AL, 1'b0);
      ALUSrcE = 1'b1;
      chk(K_RES, 32'h8000_0000, "orr_imm_res");
      step();
      set_op(ADD, 32'd1, 32'd1, 2'b00, LT, 1'b1);
      chk(K_FLAGS, 32'b1010, "orr_flags_cv_kept");
      chk(K_RW, 32'd1, "lt_rw");
      step();
      set_op(ADD, 32'd1, 32'd1, 2'b00, GE, 1'b1);
      MemWriteE = 1'b1;
      chk(K_RW, 32'd0, "ge_rw");
      chk(K_MW, 32'd0, "ge_mw");
      step();

      // SUB with borrow
      set_op(SUB, 32'd3, 32'd5, 2'b11, AL, 1'b0);
      PCSrcE = 1'b1;
      MemWriteE = 1'b1;
      chk(K_RES, 32'hFFFF_FFFE, "sub_borrow_res");
      chk(K_PC, 32'd1, "al_pc");
      chk(K_MW, 32'd1, "al_mw");
      step();
      nop();
      chk(K_FLAGS, 32'b1000, "sub_borrow_flags");
      #1;
      vectors++;
      if (FlagsE !== 4'b1000) begin
         miscompares++;
         $display("FAIL sub_borrow_flags_direct: got %b", FlagsE);
      end
      step();

      // MUL 0x12345 * 0x1000
      set_op(MUL, 32'h0001_2345, 32'h0000_1000, 2'b00, AL, 1'b1);
      run_multi("mul");
      chk(K_RES, 32'h1234_5000, "mul_res");
      #1;
      vectors++;
      if (ALUResultM !== 32'h1234_5000) begin
         miscompares++;
         $display("FAIL mul_res_direct: got %h", ALUResultM);
      end
      step();
      nop();
      chk(K_STALL, 32'd0, "mul_after_stall");
      chk(K_FLAGS, 32'b1000, "mul_flags_kept");
      step();

      // modulo 1000 % 7 with N,Z write; C=1 must survive
      set_op(SUB, 32'd5, 32'd5, 2'b11, AL, 1'b0);
      step();
      set_op(MOD, 32'd1000, 32'd7, 2'b10, AL, 1'b1);
      run_multi("mod7");
      chk(K_RES, 32'd6, "mod7_res");
      #1;
      vectors++;
      if (ALUResultM !== 32'd6) begin
         miscompares++;
         $display("FAIL mod7_res_direct: got %h", ALUResultM);
      end
      step();
      nop();
      chk(K_FLAGS, 32'b0010, "mod7_flags");
      step();

      // modulo 9 % 0 (divisor from immediate)
      set_op(MOD, 32'd9, 32'd5, 2'b00, AL, 1'b1);
      ALUSrcE = 1'b1;
      run_multi("mod0");
      chk(K_RES, 32'd9, "mod0_res");
      #1;
      vectors++;
      if (ALUResultM !== 32'd9) begin
         miscompares++;
         $display("FAIL mod0_res_direct: got %h", ALUResultM);
      end
      step();
      nop();
      step();

      // MUL not executed (EQ with Z=0)
      set_op(MUL, 32'd3, 32'd3, 2'b10, EQ, 1'b1);
      chk(K_STALL, 32'd0, "mul_skip_stall");
      chk(K_RW, 32'd0, "mul_skip_rw");
      step();
      nop();
      chk(K_STALL, 32'd0, "mul_skip_after");
      chk(K_FLAGS, 32'b0010, "mul_skip_flags");
      step();

      // reset during BUSY cycle 10
      set_op(MUL, 32'd7, 32'd9, 2'b11, AL, 1'b1);
      chk(K_STALL, 32'd1, "rst_issue_stall");
      step();
      for (int i = 1; i < 10; i++) begin
         chk(K_STALL, 32'd1, "rst_busy_stall");
         step();
      end
      rst = 1'b1;
      chk(K_STALL, 32'd1, "rst_busy10_stall");
      step();
      rst = 1'b0;
      set_op(ADD, 32'hFFFF_FFFF, 32'h1, 2'b11, AL, 1'b1);
      chk(K_STALL, 32'd0, "rst_abort_stall");
      chk(K_FLAGS, 32'b0000, "rst_abort_flags");
      chk(K_RES, 32'd0, "post_rst_add_res");
      chk(K_RW, 32'd1, "post_rst_add_rw");
      step();
      nop();
      chk(K_FLAGS, 32'b0110, "post_rst_add_flags");
      chk(K_STALL, 32'd0, "post_rst_idle");
      step();

      @(negedge clk);
      #1;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s: expectation for cycle %0d never checked, expected %h", e.name, e.cyc, e.val);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
